// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-macro signals around mem_port_arbiter.
// slave: arbiter view; master: requester/memory view (fetch, mem stage, macro).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall_if;
    logic              stall_mem;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (if_*) and data (d_*) requesters.
// Ports: clk, rst_n (async, active low), bus (slave modport: requests, grants,
// read returns, memory strobes, stall_if/stall_mem).
// ARB_ROUND_ROBIN_EN: conflicts go to the requester not granted last;
// otherwise data has priority, with fetch forced after STARVE_MAX data grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LAT_W-1:0] lat_cnt;
    logic [LAT_W-1:0] lat_nxt;
    logic             owner_d;
    logic             owner_nxt;
    logic             pick_if;
    logic             pick_d;
    logic             rv_if;
    logic             rv_d;
    logic             gnt_if;
    logic             gnt_d;
    logic             fetch_first;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = data was granted last, so fetch wins the next conflict.
    logic last_d;

    assign fetch_first = last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d <= 1'b1;
        end else if (gnt_if) begin
            last_d <= 1'b0;
        end else if (gnt_d) begin
            last_d <= 1'b1;
        end
    end
`else
    localparam int SC_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

    logic [SC_W-1:0] starve_cnt;

    assign fetch_first = (starve_cnt == SC_MAX);

    // Counts data grants that overtook a waiting fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!bus.if_req || gnt_if) begin
            starve_cnt <= '0;
        end else if (gnt_d && !fetch_first) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lat_cnt <= '0;
            owner_d <= 1'b0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_nxt;
            owner_d <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lat_nxt   = lat_cnt;
        owner_nxt = owner_d;
        pick_if   = 1'b0;
        pick_d    = 1'b0;
        rv_if     = 1'b0;
        rv_d      = 1'b0;
        unique case (state)
            IDLE: begin
                pick_if = bus.if_req & (~bus.d_req | fetch_first);
                pick_d  = bus.d_req & ~pick_if;
                // Writes complete at the grant edge; only reads occupy the port.
                if (pick_if | (pick_d & ~bus.d_we)) begin
                    state_nxt = BUSY;
                    lat_nxt   = LAT_INIT;
                    owner_nxt = pick_d;
                end
            end
            BUSY: begin
                if (lat_cnt == '0) begin
                    rv_if     = ~owner_d;
                    rv_d      = owner_d;
                    state_nxt = IDLE;
                end else begin
                    lat_nxt = lat_cnt - LAT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Requests are transparent, so outputs are also forced low while in reset.
    assign gnt_if = rst_n & pick_if;
    assign gnt_d  = rst_n & pick_d;

    assign bus.if_gnt    = gnt_if;
    assign bus.d_gnt     = gnt_d;
    assign bus.mem_req   = gnt_if | gnt_d;
    assign bus.mem_we    = gnt_d & bus.d_we;
    assign bus.mem_addr  = gnt_d  ? bus.d_addr :
                           gnt_if ? bus.if_addr : '0;
    assign bus.mem_wdata = bus.mem_we ? bus.d_wdata : '0;
    assign bus.mem_be    = bus.mem_we ? bus.d_be : '0;

    assign bus.if_rvalid = rst_n & rv_if;
    assign bus.d_rvalid  = rst_n & rv_d;
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
    assign bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : '0;

    assign bus.stall_if  = rst_n & bus.if_req & ~gnt_if;
    assign bus.stall_mem = rst_n & ((bus.d_req & ~gnt_d) |
                           ((state == BUSY) & owner_d & ~rv_d));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a cycle-indexed transaction model.
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SM  = 4;
    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst3_n;
    logic        ld_en;
    logic [31:0] ld_seed;
    int          n_chk = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SM)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_MAX(SM)
    ) u_dut3 (
        .clk(clk), .rst_n(rst3_n), .bus(bus3)
    );

    function automatic logic [31:0] init_word(int i, logic [31:0] seed);
        if (seed == 32'h0)
            return (i == 64) ? 32'h0050_0093 : {16'hA5A5, 16'(i)};
        return seed ^ (32'(i) * 32'h9E37_79B9);
    endfunction

    // Memory macro model for the MEM_LAT=1 instance.
    logic [31:0] mem [1024];
    logic [31:0] shadow [1024];
    logic [31:0] rd_q;

    always @(posedge clk) begin
        if (ld_en) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i, ld_seed);
        end else if (bus.mem_req && bus.mem_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_be[b])
                    mem[bus.mem_addr[11:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
        end else if (bus.mem_req) begin
            rd_q <= mem[bus.mem_addr[11:2]];
        end
    end
    assign bus.mem_rdata = rd_q;

    // Three-cycle macro for the MEM_LAT=3 instance; returns ~addr.
    logic [31:0] p3 [3];
    always @(posedge clk) begin
        p3[0] <= (bus3.mem_req && !bus3.mem_we) ? ~bus3.mem_addr : 32'h0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign bus3.mem_rdata = p3[2];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_main();
        bus.if_req = 0; bus.if_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0;
        bus.d_wdata = '0; bus.d_be = '0;
    endtask

    task automatic idle3();
        bus3.if_req = 0; bus3.if_addr = '0;
        bus3.d_req = 0; bus3.d_we = 0; bus3.d_addr = '0;
        bus3.d_wdata = '0; bus3.d_be = '0;
    endtask

    task automatic test_reset();
        rst_n = 0; rst3_n = 0;
        ld_seed = 32'h0; ld_en = 1;
        bus.if_req = 1; bus.if_addr = 32'h10;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h20;
        bus.d_wdata = 32'hFFFF_FFFF; bus.d_be = 4'hF;
        @(negedge clk);
        n_chk += 6;
        if (bus.if_gnt !== 1'b0 || bus.d_gnt !== 1'b0) begin
            n_bad++; $display("FAIL rst_gnt got if=%b d=%b want 0", bus.if_gnt, bus.d_gnt);
        end
        if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin
            n_bad++; $display("FAIL rst_mem got req=%b we=%b want 0", bus.mem_req, bus.mem_we);
        end
        if (bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.mem_be !== '0) begin
            n_bad++; $display("FAIL rst_mem_bus got addr=%h wd=%h want 0", bus.mem_addr, bus.mem_wdata);
        end
        if (bus.stall_if !== 1'b0 || bus.stall_mem !== 1'b0) begin
            n_bad++; $display("FAIL rst_stall got %b%b want 00", bus.stall_if, bus.stall_mem);
        end
        if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL rst_rvalid got %b%b want 00", bus.if_rvalid, bus.d_rvalid);
        end
        if (bus.if_rdata !== '0 || bus.d_rdata !== '0) begin
            n_bad++; $display("FAIL rst_rdata got %h %h want 0", bus.if_rdata, bus.d_rdata);
        end
        idle_main();
        cyc();
        ld_en = 0; rst_n = 1; rst3_n = 1;
        @(negedge clk);
        n_chk++;
        if (bus.mem_req !== 1'b0 || bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL rel_idle got req=%b rv=%b%b want 0", bus.mem_req, bus.if_rvalid, bus.d_rvalid);
        end
        cyc();
    endtask

    task automatic test_fetch_alone();
        bus.if_req = 1; bus.if_addr = 32'h100;
        @(negedge clk);
        n_chk += 3;
        if (bus.if_gnt !== 1'b1 || bus.stall_if !== 1'b0) begin
            n_bad++; $display("FAIL fetch_gnt got gnt=%b stall=%b want 1 0", bus.if_gnt, bus.stall_if);
        end
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h100) begin
            n_bad++; $display("FAIL fetch_mem got req=%b we=%b addr=%h want 1 0 100", bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        if (bus.if_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL fetch_early_rv got %b want 0", bus.if_rvalid);
        end
        cyc();
        idle_main();
        @(negedge clk);
        n_chk += 2;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h0050_0093) begin
            n_bad++; $display("FAIL fetch_rdata got rv=%b data=%h want 1 00500093", bus.if_rvalid, bus.if_rdata);
        end
        if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== '0) begin
            n_bad++; $display("FAIL fetch_d_side got rv=%b data=%h want 0 0", bus.d_rvalid, bus.d_rdata);
        end
        cyc();
        @(negedge clk);
        n_chk++;
        if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== '0) begin
            n_bad++; $display("FAIL fetch_pulse got rv=%b data=%h want 0 0", bus.if_rvalid, bus.if_rdata);
        end
        cyc();
    endtask

    task automatic test_conflict();
        bus.if_req = 1; bus.if_addr = 32'h104;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h2000;
        @(negedge clk);
        n_chk += 2;
        if (bus.d_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin
            n_bad++; $display("FAIL conf_gnt got d=%b if=%b want 1 0", bus.d_gnt, bus.if_gnt);
        end
        if (bus.stall_if !== 1'b1 || bus.stall_mem !== 1'b0) begin
            n_bad++; $display("FAIL conf_stall got if=%b mem=%b want 1 0", bus.stall_if, bus.stall_mem);
        end
        cyc();
        bus.d_req = 0;
        @(negedge clk);
        n_chk += 3;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hA5A5_0000) begin
            n_bad++; $display("FAIL conf_drdata got rv=%b data=%h want 1 a5a50000", bus.d_rvalid, bus.d_rdata);
        end
        if (bus.if_gnt !== 1'b0 || bus.stall_if !== 1'b1) begin
            n_bad++; $display("FAIL conf_busy got gnt=%b stall=%b want 0 1", bus.if_gnt, bus.stall_if);
        end
        if (bus.stall_mem !== 1'b0) begin
            n_bad++; $display("FAIL conf_stall_mem got %b want 0", bus.stall_mem);
        end
        cyc();
        @(negedge clk);
        n_chk++;
        if (bus.if_gnt !== 1'b1 || bus.mem_addr !== 32'h104) begin
            n_bad++; $display("FAIL conf_if_late got gnt=%b addr=%h want 1 104", bus.if_gnt, bus.mem_addr);
        end
        cyc();
        bus.if_req = 0;
        @(negedge clk);
        n_chk++;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hA5A5_0041) begin
            n_bad++; $display("FAIL conf_ifdata got rv=%b data=%h want 1 a5a50041", bus.if_rvalid, bus.if_rdata);
        end
        cyc();
    endtask

    task automatic test_writes_back_to_back();
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h40;
        bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk += 3;
            if (bus.d_gnt !== 1'b1 || bus.mem_we !== 1'b1) begin
                n_bad++; $display("FAIL wr_gnt[%0d] got gnt=%b we=%b want 1 1", k, bus.d_gnt, bus.mem_we);
            end
            if (bus.mem_be !== 4'b0011 || bus.mem_wdata !== 32'hDEAD_BEEF) begin
                n_bad++; $display("FAIL wr_bus[%0d] got be=%b wd=%h want 0011 deadbeef", k, bus.mem_be, bus.mem_wdata);
            end
            if (bus.d_rvalid !== 1'b0) begin
                n_bad++; $display("FAIL wr_rvalid[%0d] got %b want 0", k, bus.d_rvalid);
            end
            cyc();
        end
        bus.d_we = 0;
        @(negedge clk);
        n_chk++;
        if (bus.d_rvalid !== 1'b0 || bus.d_gnt !== 1'b1) begin
            n_bad++; $display("FAIL wr_after got rv=%b gnt=%b want 0 1", bus.d_rvalid, bus.d_gnt);
        end
        cyc();
        idle_main();
        @(negedge clk);
        n_chk++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hA5A5_BEEF) begin
            n_bad++; $display("FAIL wr_readback got rv=%b data=%h want 1 a5a5beef", bus.d_rvalid, bus.d_rdata);
        end
        cyc();
    endtask

    task automatic test_starvation();
        bit got [$];
        bit exp [6];
`ifdef ARB_ROUND_ROBIN_EN
        exp = '{1, 0, 1, 0, 1, 0};
`else
        exp = '{1, 1, 1, 1, 0, 1};
`endif
        bus.if_req = 1; bus.if_addr = 32'h200;
        @(negedge clk);
        n_chk++;
        if (bus.if_gnt !== 1'b1) begin
            n_bad++; $display("FAIL starve_pre got %b want 1", bus.if_gnt);
        end
        cyc();
        bus.if_req = 0;
        cyc();
        bus.if_req = 1;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h300;
        bus.d_wdata = 32'h1111_2222; bus.d_be = 4'hF;
        for (int k = 0; k < 30 && got.size() < 6; k++) begin
            @(negedge clk);
            if (bus.if_gnt === 1'b1) got.push_back(1'b0);
            if (bus.d_gnt === 1'b1) got.push_back(1'b1);
            cyc();
        end
        n_chk++;
        if (got.size() < 6) begin
            n_bad++; $display("FAIL starve_count got %0d grants want 6", got.size());
        end
        for (int k = 0; k < 6 && k < got.size(); k++) begin
            n_chk++;
            if (got[k] !== exp[k]) begin
                n_bad++; $display("FAIL starve_seq[%0d] got d=%b want d=%b", k, got[k], exp[k]);
            end
        end
        idle_main();
        cyc(); cyc();
    endtask

    task automatic test_reset_mid_read();
        bus3.d_req = 1; bus3.d_we = 0; bus3.d_addr = 32'h80;
        @(negedge clk);
        n_chk++;
        if (bus3.d_gnt !== 1'b1) begin
            n_bad++; $display("FAIL mid_gnt got %b want 1", bus3.d_gnt);
        end
        cyc();
        idle3();
        @(negedge clk);
        n_chk++;
        if (bus3.stall_mem !== 1'b1 || bus3.d_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL mid_busy got stall=%b rv=%b want 1 0", bus3.stall_mem, bus3.d_rvalid);
        end
        rst3_n = 0;
        bus3.d_req = 1;
        #1;
        n_chk += 2;
        if (bus3.d_gnt !== 1'b0 || bus3.mem_req !== 1'b0 || bus3.stall_mem !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst got gnt=%b req=%b stall=%b want 0", bus3.d_gnt, bus3.mem_req, bus3.stall_mem);
        end
        if (bus3.d_rvalid !== 1'b0 || bus3.d_rdata !== '0 || bus3.mem_addr !== '0) begin
            n_bad++; $display("FAIL mid_rst_data got rv=%b data=%h addr=%h want 0", bus3.d_rvalid, bus3.d_rdata, bus3.mem_addr);
        end
        idle3();
        cyc(); cyc();
        rst3_n = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_chk++;
            if (bus3.d_rvalid !== 1'b0 || bus3.if_rvalid !== 1'b0) begin
                n_bad++; $display("FAIL mid_ghost[%0d] got rv=%b%b want 00", k, bus3.if_rvalid, bus3.d_rvalid);
            end
            cyc();
        end
        bus3.d_req = 1; bus3.d_addr = 32'h84;
        @(negedge clk);
        n_chk++;
        if (bus3.d_gnt !== 1'b1) begin
            n_bad++; $display("FAIL mid_idle_gnt got %b want 1", bus3.d_gnt);
        end
        cyc();
        idle3();
        cyc(); cyc();
        @(negedge clk);
        n_chk++;
        if (bus3.d_rvalid !== 1'b1 || bus3.d_rdata !== ~32'h84) begin
            n_bad++; $display("FAIL mid_lat3 got rv=%b data=%h want 1 %h", bus3.d_rvalid, bus3.d_rdata, ~32'h84);
        end
        cyc();
    endtask

    task automatic test_random();
        bit ip = 0, dp = 0, ip0, ff, eig, edg, eirv, edrv, esm, rv_d = 0, last_d = 1;
        int nf = 0, rv_at = -10, starve = 0;
        logic [31:0] rv_x = '0, ea;
        rst_n = 0;
        idle_main();
        ld_seed = 32'h1357_9BDF; ld_en = 1;
        for (int i = 0; i < 1024; i++) shadow[i] = init_word(i, ld_seed);
        cyc();
        ld_en = 0; rst_n = 1;
        for (int n = 0; n < 300; n++) begin
            if (!ip && $urandom_range(0, 99) < 55) begin
                ip = 1;
                bus.if_addr = 32'($urandom_range(0, 1023)) << 2;
            end
            if (!dp && $urandom_range(0, 99) < 55) begin
                dp = 1;
                bus.d_we = 1'($urandom_range(0, 1));
                bus.d_addr = 32'($urandom_range(0, 1023)) << 2;
                bus.d_wdata = $urandom();
                bus.d_be = 4'($urandom_range(1, 15));
            end
            bus.if_req = ip; bus.d_req = dp;
            @(negedge clk);
            eirv = (n == rv_at) && !rv_d;
            edrv = (n == rv_at) && rv_d;
            eig = 0; edg = 0;
            if (n >= nf) begin
`ifdef ARB_ROUND_ROBIN_EN
                ff = last_d;
`else
                ff = (starve >= SM);
`endif
                eig = ip && (!dp || ff);
                edg = dp && !eig;
            end
            esm = (dp && !edg) || (rv_d && n > rv_at - LAT && n < rv_at);
            ea = eig ? bus.if_addr : edg ? bus.d_addr : '0;
            n_chk += 7;
            if (bus.if_gnt !== eig || bus.d_gnt !== edg) begin
                n_bad++; $display("FAIL rnd_gnt c%0d got if=%b d=%b want %b %b", n, bus.if_gnt, bus.d_gnt, eig, edg);
            end
            if (bus.if_rvalid !== eirv || bus.d_rvalid !== edrv) begin
                n_bad++; $display("FAIL rnd_rvalid c%0d got %b%b want %b%b", n, bus.if_rvalid, bus.d_rvalid, eirv, edrv);
            end
            if (bus.if_rdata !== (eirv ? rv_x : 32'h0)) begin
                n_bad++; $display("FAIL rnd_if_rdata c%0d got %h want %h", n, bus.if_rdata, eirv ? rv_x : 32'h0);
            end
            if (bus.d_rdata !== (edrv ? rv_x : 32'h0)) begin
                n_bad++; $display("FAIL rnd_d_rdata c%0d got %h want %h", n, bus.d_rdata, edrv ? rv_x : 32'h0);
            end
            if (bus.stall_if !== (ip && !eig) || bus.stall_mem !== esm) begin
                n_bad++; $display("FAIL rnd_stall c%0d got %b%b want %b%b", n, bus.stall_if, bus.stall_mem, ip && !eig, esm);
            end
            if (bus.mem_req !== (eig || edg) || bus.mem_addr !== ea) begin
                n_bad++; $display("FAIL rnd_mem c%0d got req=%b addr=%h want %b %h", n, bus.mem_req, bus.mem_addr, eig || edg, ea);
            end
            if (bus.mem_we !== (edg && bus.d_we)) begin
                n_bad++; $display("FAIL rnd_we c%0d got %b want %b", n, bus.mem_we, edg && bus.d_we);
            end
            ip0 = ip;
            if (eig) begin
                nf = n + LAT + 1; rv_at = n + LAT; rv_d = 0;
                rv_x = shadow[bus.if_addr[11:2]];
                ip = 0; last_d = 0;
            end
            if (edg) begin
                dp = 0; last_d = 1;
                if (bus.d_we) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.d_be[b])
                            shadow[bus.d_addr[11:2]][b*8 +: 8] = bus.d_wdata[b*8 +: 8];
                end else begin
                    nf = n + LAT + 1; rv_at = n + LAT; rv_d = 1;
                    rv_x = shadow[bus.d_addr[11:2]];
                end
            end
            if (!ip0 || eig) starve = 0;
            else if (edg && starve < SM) starve++;
            cyc();
        end
        idle_main();
        cyc(); cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 0; rst3_n = 0; ld_en = 0; ld_seed = '0;
        idle_main();
        idle3();
        test_reset();
        test_fetch_alone();
        test_conflict();
        test_writes_back_to_back();
        test_starvation();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
